// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a write-strobe FIFO in front of it.
// Bytes are popped by the line FSM when idle and shifted out LSB first.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int AW         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          overflow,
    output logic          UART_RXD_OUT
);

    localparam int DIVISOR = CLK_FREQ / BAUD;
    localparam int BW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [BW-1:0] BCNT_LAST = BW'(DIVISOR - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bi_q, bi_d;
    logic [7:0]    sh_q, sh_d;
    logic          line_q, line_d;

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic push, pop, bit_end;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push    = wr_en && !full;
    assign pop     = (state_q == IDLE) && !empty;
    assign bit_end = (bcnt_q == BCNT_LAST);

    assign count        = count_q;
    assign busy         = (state_q != IDLE);
    assign overflow     = overflow_q;
    assign UART_RXD_OUT = line_q;

    // NOTE: storage has no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q    <= count_d;
            overflow_q <= overflow_q | (wr_en & full);
        end
    end

    // NOTE: every next-state signal gets its hold value first, so no latches are inferred.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        bi_d    = bi_q;
        sh_d    = sh_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                line_d = 1'b1;
                if (!empty) begin
                    sh_d    = mem_q[rd_ptr_q];
                    line_d  = 1'b0;
                    bcnt_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bcnt_d  = '0;
                    bi_d    = '0;
                    line_d  = sh_q[0];
                    state_d = DATA;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bcnt_d = '0;
                    if (bi_q != 3'd7) begin
                        bi_d   = bi_q + 3'd1;
                        line_d = sh_q[bi_q + 3'd1];
                    end else begin
                        line_d  = 1'b1;
                        state_d = STOP;
                    end
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    bcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset abandons any frame in flight and drives the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            bi_q    <= '0;
            sh_q    <= '0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            bi_q    <= bi_d;
            sh_q    <= sh_d;
            line_q  <= line_d;
        end
    end

endmodule
